// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sub-word data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        ld_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Sub-word offsets are forced to alignment; size=3 behaves as a word.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] boff);
        logic [3:0] be;
        be = 4'b1111;
        unique case (1'b1)
            (size == SZ_BYTE): be = 4'b0001 << boff;
            (size == SZ_HALF): be = boff[1] ? 4'b1100 : 4'b0011;
            default:           be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Store lane replication/byte enables and load extraction/extension.
// DMEM_ALIGN_CHK_EN enables the misalignment / illegal-size flag.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [1:0]  boff,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rshift;

    assign rshift   = rword >> {boff, 3'b000};
    assign byte_sel = rshift[7:0];
    assign half_sel = boff[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be     = byte_en(size, boff);
        wlanes = wdata;
        rdata  = rword;
        unique case (1'b1)
            (size == SZ_BYTE): begin
                wlanes = {4{wdata[7:0]}};
                rdata  = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
            end
            (size == SZ_HALF): begin
                wlanes = {2{wdata[15:0]}};
                rdata  = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
            end
            default: begin
                wlanes = wdata;
                rdata  = rword;
            end
        endcase
    end

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign = ((size == SZ_HALF) && boff[0])
                    || ((size == SZ_WORD) && (boff != 2'b00))
                    || (size == 2'd3);
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_subword.sv
// Byte-enabled data memory with req/ready handshake and wait states.
// Optional alignment checking via DMEM_ALIGN_CHK_EN (see dmem_lane_fmt).
module dmem_subword
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, eff;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes, fmt_rdata, rword;
    logic          mis, go_done, wr_en;
    logic          unused_hi;

    // With zero wait states the access completes off the live inputs.
    assign eff = (state_q == IDLE)
               ? '{we, size, ld_unsigned, addr, wdata}
               : req_q;

    assign idx       = eff.addr[AW+1:2];
    assign rword     = mem[idx];
    assign unused_hi = ^eff.addr[31:AW+2];

    dmem_lane_fmt u_fmt (
        .size        (eff.size),
        .ld_unsigned (eff.ld_unsigned),
        .boff        (eff.addr[1:0]),
        .wdata       (eff.wdata),
        .rword       (rword),
        .be          (be),
        .wlanes      (wlanes),
        .rdata       (fmt_rdata),
        .misalign    (mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYC > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign go_done = (state_d == DONE) && (state_q != DONE);
    assign wr_en   = (state_q == DONE) && req_q.we && !mis;
    assign ready   = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req)
                req_q <= '{we, size, ld_unsigned, addr, wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= go_done;
            err    <= go_done & mis;
            if (go_done)
                rdata <= (eff.we || mis) ? 32'd0 : fmt_rdata;
        end
    end

    // Array has no reset; writes commit on the edge leaving DONE.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_subword.sv
// Directed self-checking bench for dmem_subword (two configurations).
// Honours DMEM_ALIGN_CHK_EN when compiled with it.
module tb_dmem_subword;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req [2];
    logic        we [2];
    logic [1:0]  size [2];
    logic        ldu [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        rvalid [2];
    logic [31:0] rdata [2];
    logic        err [2];

    int n_cmp;
    int n_err;

    logic [31:0] rd;
    logic        e;
    int          lat;

    dmem_subword #(.DEPTH(256), .WAIT_CYC(3)) u_dut0 (
        .clk (clk), .rst_n (rst_n), .req (req[0]), .we (we[0]),
        .size (size[0]), .ld_unsigned (ldu[0]), .addr (addr[0]),
        .wdata (wdata[0]), .ready (ready[0]), .rvalid (rvalid[0]),
        .rdata (rdata[0]), .err (err[0])
    );

    dmem_subword #(.DEPTH(16), .WAIT_CYC(0)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .req (req[1]), .we (we[1]),
        .size (size[1]), .ld_unsigned (ldu[1]), .addr (addr[1]),
        .wdata (wdata[1]), .ready (ready[1]), .rvalid (rvalid[1]),
        .rdata (rdata[1]), .err (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input int d, input logic w, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold,
                          output logic [31:0] r, output logic ef,
                          output int lt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_idle", 32'(ready[d]), 32'd1);
        req[d] = 1'b1; we[d] = w; size[d] = sz; ldu[d] = uns;
        addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        if (!hold) req[d] = 1'b0;
        // Scramble inputs: the DUT must work from its latched copy.
        we[d] = ~w; size[d] = 2'($urandom);
        addr[d] = $urandom; wdata[d] = $urandom;
        lt = 0;
        while (rvalid[d] !== 1'b1 && lt < 40) begin
            check("busy", 32'(ready[d]), 32'd0);
            @(posedge clk); #1;
            lt++;
        end
        check("rvalid", 32'(rvalid[d]), 32'd1);
        check("busy_done", 32'(ready[d]), 32'd0);
        r  = rdata[d];
        ef = err[d];
        req[d] = 1'b0;
        @(posedge clk); #1;
        check("rvalid_pulse", 32'(rvalid[d]), 32'd0);
        check("ready_back", 32'(ready[d]), 32'd1);
    endtask

    task automatic st(input int d, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        logic        ef;
        int          lt;
        access(d, 1'b1, sz, 1'b0, a, wd, 1'b0, r, ef, lt);
        check("st_err", 32'(ef), 32'd0);
        check("st_lat", lt, (d == 0) ? 32'd3 : 32'd0);
    endtask

    task automatic ld(input int d, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
        logic [31:0] r;
        logic        ef;
        int          lt;
        access(d, 1'b0, sz, uns, a, 32'hFFFF_FFFF, 1'b0, r, ef, lt);
        check(tag, r, exp);
        check("ld_err", 32'(ef), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; size[i] = SZ_WORD;
            ldu[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(ready[i]), 32'd1);
            check("rst_rvalid", 32'(rvalid[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Word store, then sub-word loads (WAIT_CYC=3, req held).
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, 1'b1,
               rd, e, lat);
        check("sw_lat", lat, 32'd3);
        check("sw_err", 32'(e), 32'd0);
        ld(0, SZ_BYTE, 1'b0, 32'h10, 32'h0000_0044, "lb_10");
        ld(0, SZ_BYTE, 1'b0, 32'h13, 32'h0000_0011, "lb_13");
        ld(0, SZ_BYTE, 1'b0, 32'h11, 32'h0000_0033, "lb_11");
        ld(0, SZ_HALF, 1'b0, 32'h12, 32'h0000_1122, "lh_12");
        ld(0, SZ_HALF, 1'b1, 32'h10, 32'h0000_3344, "lhu_10");
        ld(0, SZ_WORD, 1'b0, 32'h10, 32'h1122_3344, "lw_10");

        // Byte store into a zero word, sign/zero extension.
        st(0, SZ_WORD, 32'h20, 32'h0);
        st(0, SZ_BYTE, 32'h21, 32'hFFFF_FFA5);
        ld(0, SZ_WORD, 1'b0, 32'h20, 32'h0000_A500, "sb_word");
        ld(0, SZ_BYTE, 1'b0, 32'h21, 32'hFFFF_FFA5, "lb_21");
        ld(0, SZ_BYTE, 1'b1, 32'h21, 32'h0000_00A5, "lbu_21");
        st(0, SZ_HALF, 32'h22, 32'h1234_BEEF);
        ld(0, SZ_WORD, 1'b0, 32'h20, 32'hBEEF_A500, "sh_word");
        ld(0, SZ_HALF, 1'b0, 32'h22, 32'hFFFF_BEEF, "lh_22");
        ld(0, SZ_HALF, 1'b1, 32'h22, 32'h0000_BEEF, "lhu_22");

        // Address wrap modulo DEPTH words.
        st(0, SZ_WORD, 32'h400, 32'hDEAD_BEEF);
        ld(0, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, "wrap");

        // Misaligned / illegal accesses.
        st(0, SZ_WORD, 32'h30, 32'h5566_7788);
        access(0, 1'b1, SZ_HALF, 1'b0, 32'h31, 32'h0000_CAFE, 1'b0,
               rd, e, lat);
`ifdef DMEM_ALIGN_CHK_EN
        check("sh31_err", 32'(e), 32'd1);
        ld(0, SZ_WORD, 1'b0, 32'h30, 32'h5566_7788, "sh31_nowr");
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h32, 32'h0, 1'b0, rd, e, lat);
        check("lw32_err", 32'(e), 32'd1);
        check("lw32_rdata", rd, 32'd0);
        access(0, 1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 1'b0, rd, e, lat);
        check("sz3_err", 32'(e), 32'd1);
        check("sz3_rdata", rd, 32'd0);
`else
        check("sh31_err", 32'(e), 32'd0);
        ld(0, SZ_WORD, 1'b0, 32'h30, 32'h5566_CAFE, "sh31_wr");
        ld(0, SZ_WORD, 1'b0, 32'h32, 32'h5566_CAFE, "lw32_align");
        ld(0, 2'd3, 1'b0, 32'h30, 32'h5566_CAFE, "sz3_word");
`endif

        // Reset during WAIT drops the pending store.
        st(0, SZ_WORD, 32'h40, 32'h1111_1111);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = SZ_WORD;
        addr[0] = 32'h40; wdata[0] = 32'h9999_9999;
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("mid_busy", 32'(ready[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready[0]), 32'd1);
        check("mid_rst_rvalid", 32'(rvalid[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rvalid_low", 32'(rvalid[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_ready_rel", 32'(ready[0]), 32'd1);
        check("mid_rvalid_rel", 32'(rvalid[0]), 32'd0);
        ld(0, SZ_WORD, 1'b0, 32'h40, 32'h1111_1111, "mid_old");

        // Zero wait states, small DEPTH with wrap.
        st(1, SZ_WORD, 32'h8, 32'hCAFE_F00D);
        ld(1, SZ_HALF, 1'b0, 32'hA, 32'hFFFF_CAFE, "w0_lh");
        ld(1, SZ_BYTE, 1'b1, 32'h8, 32'h0000_000D, "w0_lbu");
        st(1, SZ_BYTE, 32'h4B, 32'h0000_0077);
        ld(1, SZ_WORD, 1'b0, 32'h8, 32'h77FE_F00D, "w0_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
